// File: rtl/sys_write_buffer.sv
// rtl/sys_write_buffer.sv - posted-write buffer between cache controller and system bus
module sys_write_buffer #(
    parameter int DEPTH     = 4,
    parameter int ADDRWIDTH = 16,
    parameter int DATAWIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 CStrobe,
    input  logic                 CRW,
    input  logic [ADDRWIDTH-1:0] CAddr,
    input  logic [DATAWIDTH-1:0] CWrData,
    output logic                 CReady,
    output logic [DATAWIDTH-1:0] CRdData,
    output logic                 SysStrobe,
    output logic                 SysRW,
    output logic [ADDRWIDTH-1:0] SysAddr,
    output logic [DATAWIDTH-1:0] SysWrData,
    input  logic [DATAWIDTH-1:0] SysRdData,
    input  logic                 SysReady,
    output logic                 Full,
    output logic                 Empty
);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WR_BUS, RD_BUS, RD_DONE} busState_t;

    busState_t state, stateNext;

    logic [ADDRWIDTH-1:0] addrMem [DEPTH];
    logic [DATAWIDTH-1:0] dataMem [DEPTH];
    logic [PTRW-1:0]      wrPtr, rdPtr;
    logic [CNTW-1:0]      count;
    logic                 rdPending;
    logic [ADDRWIDTH-1:0] rdAddr;

    logic                 reqOk, push, pop, readHit, readMiss, busRdDone, hit;
    logic [DATAWIDTH-1:0] hitData;
    logic                 strobeNext, rwNext;
    logic [ADDRWIDTH-1:0] addrNext;
    logic [DATAWIDTH-1:0] wrDataNext;

    assign Empty = (count == '0);
    assign Full  = (count == CNTW'(DEPTH));

    // A held request is not resampled while its completion pulse is out or a miss is pending.
    assign reqOk    = CStrobe && !CReady && !rdPending;
    assign push     = reqOk && !CRW && !Full;
    assign readHit  = reqOk && CRW && hit;
    assign readMiss = reqOk && CRW && !hit;

    // Scan oldest to youngest so the last match wins; the head on the bus is still valid.
    always_comb begin
        hit     = 1'b0;
        hitData = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNTW'(i) < count && addrMem[rdPtr + PTRW'(i)] == CAddr) begin
                hit     = 1'b1;
                hitData = dataMem[rdPtr + PTRW'(i)];
            end
        end
    end

    always_comb begin
        stateNext  = state;
        strobeNext = SysStrobe;
        rwNext     = SysRW;
        addrNext   = SysAddr;
        wrDataNext = SysWrData;
        pop        = 1'b0;
        busRdDone  = 1'b0;
        case (state)
            IDLE: begin
                if (rdPending) begin
                    stateNext  = RD_BUS;
                    strobeNext = 1'b1;
                    rwNext     = 1'b1;
                    addrNext   = rdAddr;
                end else if (!Empty) begin
                    stateNext  = WR_BUS;
                    strobeNext = 1'b1;
                    rwNext     = 1'b0;
                    addrNext   = addrMem[rdPtr];
                    wrDataNext = dataMem[rdPtr];
                end
            end
            WR_BUS: begin
                if (SysReady && SysStrobe) begin
                    pop        = 1'b1;
                    strobeNext = 1'b0;
                    stateNext  = IDLE;
                end
            end
            RD_BUS: begin
                if (SysReady && SysStrobe) begin
                    busRdDone  = 1'b1;
                    strobeNext = 1'b0;
                    stateNext  = RD_DONE;
                end
            end
            RD_DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            addrMem[wrPtr] <= CAddr;
            dataMem[wrPtr] <= CWrData;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            rdPending <= 1'b0;
            rdAddr    <= '0;
            CReady    <= 1'b0;
            CRdData   <= '0;
            SysStrobe <= 1'b0;
            SysRW     <= 1'b1;
            SysAddr   <= '0;
            SysWrData <= '0;
        end else begin
            state     <= stateNext;
            SysStrobe <= strobeNext;
            SysRW     <= rwNext;
            SysAddr   <= addrNext;
            SysWrData <= wrDataNext;
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            CReady <= push || readHit || busRdDone;
            if (readHit)        CRdData <= hitData;
            else if (busRdDone) CRdData <= SysRdData;
            if (readMiss) begin
                rdPending <= 1'b1;
                rdAddr    <= CAddr;
            end else if (busRdDone) begin
                rdPending <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sys_write_buffer.sv
// tb/tb_sys_write_buffer.sv - directed scoreboard bench for sys_write_buffer
module tb_sys_write_buffer;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        CStrobe, CRW;
    logic [15:0] CAddr;
    logic [31:0] CWrData;
    logic        CReady;
    logic [31:0] CRdData;
    logic        SysStrobe, SysRW;
    logic [15:0] SysAddr;
    logic [31:0] SysWrData;
    logic [31:0] SysRdData;
    logic        SysReady;
    logic        Full, Empty;

    int checks = 0;
    int failures = 0;

    logic [48:0] expBus[$];
    logic [31:0] expRd[$];

    int          busCredits = 0;
    int          busLatency = 1;
    logic [31:0] busRdValue = '0;
    int          waitCnt = 0;
    int          strobeSeen = 0;
    int          rdStrobeSeen = 0;

    sys_write_buffer #(.DEPTH(4), .ADDRWIDTH(16), .DATAWIDTH(32)) dut (
        .Clk(Clk), .Reset(Reset), .CStrobe(CStrobe), .CRW(CRW), .CAddr(CAddr),
        .CWrData(CWrData), .CReady(CReady), .CRdData(CRdData), .SysStrobe(SysStrobe),
        .SysRW(SysRW), .SysAddr(SysAddr), .SysWrData(SysWrData), .SysRdData(SysRdData),
        .SysReady(SysReady), .Full(Full), .Empty(Empty)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [48:0] busTxn(input logic rw, input logic [15:0] a, input logic [31:0] d);
        return {rw, a, rw ? 32'h0 : d};
    endfunction

    // Memory model: completes strobes after busLatency negedges while credits remain.
    initial begin
        SysReady  = 1'b0;
        SysRdData = '0;
        forever begin
            @(negedge Clk);
            if (SysStrobe) strobeSeen++;
            if (SysStrobe && SysRW) rdStrobeSeen++;
            if (SysReady || !SysStrobe || !Reset) begin
                SysReady = 1'b0;
                waitCnt  = 0;
            end else if (busCredits > 0) begin
                waitCnt++;
                if (waitCnt >= busLatency) begin
                    SysReady  = 1'b1;
                    SysRdData = busRdValue;
                    busCredits--;
                    if (expBus.size() == 0) chk("bus_unexpected", 1, 0);
                    else chk("bus_txn", busTxn(SysRW, SysAddr, SysWrData), expBus.pop_front());
                end
            end
        end
    end

    task automatic cpuWrite(input logic [15:0] a, input logic [31:0] d, output int lat);
        @(negedge Clk);
        CStrobe = 1'b1; CRW = 1'b0; CAddr = a; CWrData = d;
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge Clk);
            if (CReady) begin lat = i; break; end
        end
        chk("wr_ack", lat != 0, 1);
        CStrobe = 1'b0;
    endtask

    task automatic cpuRead(input logic [15:0] a, input logic [31:0] exp, output int lat);
        expRd.push_back(exp);
        @(negedge Clk);
        CStrobe = 1'b1; CRW = 1'b1; CAddr = a;
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge Clk);
            if (CReady) begin lat = i; break; end
        end
        chk("rd_ack", lat != 0, 1);
        if (lat != 0) chk("rd_data", CRdData, expRd.pop_front());
        CStrobe = 1'b0; CRW = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (expBus.size() == 0 && Empty && !SysStrobe) begin ok = 1'b1; break; end
        end
        chk(tag, ok, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        logic sawReady;
        Reset = 1'b0; CStrobe = 1'b0; CRW = 1'b0; CAddr = '0; CWrData = '0;

        // Reset held while the upstream side wiggles
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            CStrobe = 1'($urandom); CRW = 1'($urandom);
            CAddr = 16'($urandom); CWrData = $urandom;
        end
        @(negedge Clk);
        chk("rst_CReady", CReady, 0);
        chk("rst_CRdData", CRdData, 0);
        chk("rst_SysStrobe", SysStrobe, 0);
        chk("rst_SysRW", SysRW, 1);
        chk("rst_SysAddr", SysAddr, 0);
        chk("rst_SysWrData", SysWrData, 0);
        chk("rst_Full", Full, 0);
        chk("rst_Empty", Empty, 1);
        CStrobe = 1'b0; CRW = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;

        // Single write, two-cycle bus latency
        busLatency = 2; busCredits = 1000;
        expBus.push_back(busTxn(1'b0, 16'h0010, 32'hDEADBEEF));
        cpuWrite(16'h0010, 32'hDEADBEEF, lat);
        chk("t2_ack_latency", lat, 1);
        @(negedge Clk);
        chk("t2_CReady_pulse", CReady, 0);
        chk("t2_SysStrobe", SysStrobe, 1);
        chk("t2_SysRW", SysRW, 0);
        chk("t2_SysAddr", SysAddr, 16'h0010);
        chk("t2_SysWrData", SysWrData, 32'hDEADBEEF);
        waitDrain("t2_drain_empty");

        // Fill to Full, fifth write blocks until one pop
        busCredits = 0; busLatency = 1;
        for (int i = 0; i < 4; i++) begin
            expBus.push_back(busTxn(1'b0, 16'h0100 + 16'(i), 32'hA0000000 + i));
            cpuWrite(16'h0100 + 16'(i), 32'hA0000000 + i, lat);
        end
        chk("t3_full", Full, 1);
        expBus.push_back(busTxn(1'b0, 16'h0104, 32'hA0000004));
        @(negedge Clk);
        CStrobe = 1'b1; CRW = 1'b0; CAddr = 16'h0104; CWrData = 32'hA0000004;
        sawReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            sawReady |= CReady;
        end
        chk("t3_full_blocks_write", sawReady, 0);
        busCredits = 1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge Clk);
            if (CReady) begin lat = i; break; end
        end
        chk("t3_fifth_ack", lat != 0, 1);
        chk("t3_full_after_fifth", Full, 1);
        CStrobe = 1'b0;
        busCredits = 1000;
        waitDrain("t3_drain");

        // Read hit returns youngest matching write without a bus read
        busCredits = 0; rdStrobeSeen = 0;
        expBus.push_back(busTxn(1'b0, 16'h0020, 32'h11111111));
        expBus.push_back(busTxn(1'b0, 16'h0020, 32'h22222222));
        cpuWrite(16'h0020, 32'h11111111, lat);
        cpuWrite(16'h0020, 32'h22222222, lat);
        cpuRead(16'h0020, 32'h22222222, lat);
        chk("t4_hit_latency", lat, 1);
        repeat (3) @(negedge Clk);
        chk("t4_no_bus_read", rdStrobeSeen, 0);
        busCredits = 1000;
        waitDrain("t4_drain");

        // Read miss overtakes queued write but not the one already on the bus
        busCredits = 0; busLatency = 2; busRdValue = 32'hCAFEF00D;
        expBus.push_back(busTxn(1'b0, 16'h0040, 32'h40404040));
        expBus.push_back(busTxn(1'b1, 16'h0030, 32'h0));
        expBus.push_back(busTxn(1'b0, 16'h0050, 32'h50505050));
        cpuWrite(16'h0040, 32'h40404040, lat);
        cpuWrite(16'h0050, 32'h50505050, lat);
        chk("t5_w1_on_bus", {SysStrobe, SysRW, SysAddr}, {1'b1, 1'b0, 16'h0040});
        busCredits = 1000;
        cpuRead(16'h0030, 32'hCAFEF00D, lat);
        chk("t5_strobe_low_in_rd_done", SysStrobe, 0);
        waitDrain("t5_drain");

        // Asynchronous reset while a write is on the bus
        busCredits = 0; busLatency = 1;
        cpuWrite(16'h0060, 32'h60606060, lat);
        cpuWrite(16'h0061, 32'h61616161, lat);
        cpuWrite(16'h0062, 32'h62626262, lat);
        @(negedge Clk);
        chk("t6_strobe_before_reset", SysStrobe, 1);
        #2 Reset = 1'b0;
        #1;
        chk("t6_async_strobe_drop", SysStrobe, 0);
        chk("t6_async_empty", Empty, 1);
        chk("t6_async_not_full", Full, 0);
        @(negedge Clk);
        Reset = 1'b1;
        busCredits = 1000; strobeSeen = 0;
        repeat (10) @(negedge Clk);
        chk("t6_no_bus_after_reset", strobeSeen, 0);
        chk("t6_empty_after_reset", Empty, 1);
        expBus.push_back(busTxn(1'b0, 16'h0070, 32'h70707070));
        cpuWrite(16'h0070, 32'h70707070, lat);
        waitDrain("t6_post_reset_write");

        chk("sb_bus_empty", expBus.size(), 0);
        chk("sb_rd_empty", expRd.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
